// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: snoops the core store bus and transmits bytes written to
// TX_ADDR as asynchronous serial frames on tx. Bytes are buffered in a small
// circular FIFO that an FSM drains back-to-back.
// Optional feature macro: MMIO_UART_TX_PARITY_EN adds an even-parity bit
// (8E1 frames). Without it the frame is 8N1.

module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] TX_ADDR      = 16'hFF00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          WE,
    input  logic [15:0]                   address,
    input  logic [31:0]                   writeData,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic [7:0]                    drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
`ifdef MMIO_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_next;
    logic [7:0]       head_byte;

    logic             store_hit;
    logic             fifo_empty;
    logic             baud_last;
    logic             pop;
    logic             push;
    logic             drop_evt;
    logic             frame_end;
    logic             next_active;
    logic             unused_store_bits;

    // Only the low byte of a store is transmitted.
    assign unused_store_bits = ^writeData[31:8];

    assign store_hit  = WE && (address == TX_ADDR);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign head_byte  = mem[head];

    // The FSM takes a byte when idle, or when a stop bit ends with more queued.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));

    // A store into a full FIFO still fits when the FSM pops on the same edge.
    assign push     = store_hit && (!fifo_full || pop);
    assign drop_evt = store_hit && fifo_full && !pop;

    // The FSM returns to IDLE only when a stop bit ends with nothing queued.
    assign frame_end   = (state == STOP) && baud_last && fifo_empty;
    assign next_active = (state == IDLE) ? !fifo_empty : !frame_end;

    // Occupancy after this edge, shared by the FIFO counter and busy.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= writeData[7:0];
        end
    end

    // FIFO pointers, occupancy and saturating overflow counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            drop_count <= 8'd0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            fifo_count <= count_next;
            if (drop_evt && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // busy reflects the state the block is entering, so it drops with IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= next_active || (count_next != '0);
        end
    end

    // Frame sequencer; tx is registered here so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            tx         <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    tx       <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg  <= head_byte;
`ifdef MMIO_UART_TX_PARITY_EN
                        parity_bit <= ^head_byte;
`endif
                        tx         <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= 16'd0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= 16'd0;
                        if (!fifo_empty) begin
                            shift_reg  <= head_byte;
`ifdef MMIO_UART_TX_PARITY_EN
                            parity_bit <= ^head_byte;
`endif
                            tx         <= 1'b0;
                            state      <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    baud_cnt <= 16'd0;
                    tx       <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: vector table for store/status behaviour, a
// serial-line monitor checked against a scoreboard of queued bytes, and
// hand-written sequences for frame timing and reset mid-frame.

module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] ADDR = 16'hFF00;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WE = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [31:0] writeData = 32'h0;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic [7:0]  drop_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int frames_seen = 0;

    logic [7:0] sb [$];

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .TX_ADDR(ADDR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .WE(WE),
        .address(address),
        .writeData(writeData),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .fifo_full(fifo_full),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of store-bus inputs; accepted bytes go to the scoreboard.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [31:0] data, input bit accept);
        WE = we;
        address = addr;
        writeData = data;
        if (accept) sb.push_back(data[7:0]);
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) checkOutput({name, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    // Serial monitor: samples mid-bit, decodes frames and checks the scoreboard.
    int         mon_pos = 0;
    bit         mon_active = 1'b0;
    logic [10:0] mon_frame;
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_pos = 0;
                mon_frame = '0;
                frames_seen++;
            end
        end else begin
            mon_pos++;
            if (mon_pos % CPB == CPB / 2) mon_frame[mon_pos / CPB] = tx;
            if (mon_pos == FRAME_BITS * CPB - 1) begin
                mon_active = 1'b0;
                checkOutput("mon_start_bit", {31'd0, mon_frame[0]}, 32'd0);
                checkOutput("mon_stop_bit", {31'd0, mon_frame[FRAME_BITS-1]}, 32'd1);
`ifdef MMIO_UART_TX_PARITY_EN
                checkOutput("mon_parity", {31'd0, mon_frame[9]}, {31'd0, ^mon_frame[8:1]});
`endif
                if (sb.size() == 0) begin
                    checkOutput("mon_unexpected_frame", {24'd0, mon_frame[8:1]}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("mon_data", {24'd0, mon_frame[8:1]}, {24'd0, sb.pop_front()});
                end
            end
        end
    end

    // Sends one byte from idle and checks every bit-time and the frame length.
    task automatic sendAndCheckFrame(input string name, input logic [31:0] data);
        logic [7:0] d;
        logic       exp;
        logic [3:0] samples;
        d = data[7:0];
        applyStimulus(1'b1, ADDR, data, 1'b1);
        checkOutput({name, "_count"}, {29'd0, fifo_count}, 32'd1);
        @(negedge clk);
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (!(b == 0 && s == 0)) @(negedge clk);
                samples[s] = tx;
            end
            if (b == 0) exp = 1'b0;
            else if (b <= 8) exp = d[b-1];
            else if (FRAME_BITS == 11 && b == 9) exp = ^d;
            else exp = 1'b1;
            checkOutput($sformatf("%s_bit%0d", name, b), {28'd0, samples}, {28'd0, {4{exp}}});
        end
        @(negedge clk);
        checkOutput({name, "_busy_end"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_tx_end"}, {31'd0, tx}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
        bit          accept;
        logic [2:0]  count;
        logic        full;
        logic [7:0]  drops;
        logic        txv;
        bit          chk_busy;
        logic        busyv;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int   ovf_start;
        int   frames_before;
        int   bad;

        vecs[0] = '{1'b1, 16'hFF04, 32'h0000_0011, 1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'hFF00, 32'h0000_0022, 1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'hFF00, 32'h1234_56A1, 1'b1, 3'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'hFF00, 32'h0000_00A2, 1'b1, 3'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'hFF00, 32'h0000_00A3, 1'b1, 3'd2, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'hFF00, 32'h0000_00A4, 1'b1, 3'd3, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'hFF00, 32'h0000_00A5, 1'b1, 3'd4, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'hFF00, 32'h0000_00A6, 1'b0, 3'd4, 1'b1, 8'd1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 16'hFF00, 32'h0000_0000, 1'b0, 3'd4, 1'b1, 8'd1, 1'b1, 1'b1, 1'b1};
        ovf_start = 0;

        // Reset, with a store on the bus that must be ignored.
        rst = 1'b1;
        WE = 1'b1;
        address = ADDR;
        writeData = 32'h0000_0099;
        repeat (3) @(negedge clk);
        WE = 1'b0;
        checkOutput("rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("rst_full", {31'd0, fifo_full}, 32'd0);
        checkOutput("rst_drops", {24'd0, drop_count}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("post_rst_tx", {31'd0, tx}, 32'd1);

        // Vector table: wrong address, WE low, then six back-to-back stores.
        frames_before = frames_seen;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].accept);
            checkOutput($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].count});
            checkOutput($sformatf("vec%0d_full", i), {31'd0, fifo_full}, {31'd0, vecs[i].full});
            checkOutput($sformatf("vec%0d_drops", i), {24'd0, drop_count}, {24'd0, vecs[i].drops});
            checkOutput($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, vecs[i].txv});
            if (vecs[i].chk_busy)
                checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busyv});
            if (i == 3) ovf_start = cyc;
        end
        waitIdle("ovf", 1000);
        checkOutput("ovf_span", cyc - ovf_start, 5 * FRAME_BITS * CPB);
        checkOutput("ovf_frames", frames_seen - frames_before, 32'd5);
        checkOutput("ovf_drops", {24'd0, drop_count}, 32'd1);

        // Store to a neighbouring address must not disturb the line.
        applyStimulus(1'b1, 16'hFF04, 32'h0000_005A, 1'b0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx !== 1'b1 || fifo_count !== 3'd0) bad++;
            @(negedge clk);
        end
        checkOutput("wrong_addr_idle", bad, 32'd0);

        // Exact frame shapes.
        sendAndCheckFrame("byte55", 32'hABCD_0055);
        sendAndCheckFrame("byte00", 32'hFFFF_FF00);
        sendAndCheckFrame("byte07", 32'h0000_0007);

        // Reset during data bit 3 with a second byte queued.
        applyStimulus(1'b1, ADDR, 32'h0000_003C, 1'b1);
        applyStimulus(1'b1, ADDR, 32'h0000_00C3, 1'b1);
        checkOutput("mid_start", {31'd0, tx}, 32'd0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checkOutput("mid_no_residual", bad, 32'd0);

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
